// File: rtl/arith_mult_cst_arbiter_pkg.sv
// Shared sizing and the grant picker for arith_mult_cst_arbiter.
// ARITH_MULT_CST_ARB_RR_EN (used by the top) selects round-robin over fixed priority.
package arith_mult_cst_arbiter_pkg;

    localparam int               NB_REQ    = 4;
    localparam int               IN_W      = 17;
    localparam int               CST_W     = 35;
    localparam int               Z_W       = IN_W + CST_W;
    localparam logic [CST_W-1:0] CST       = 35'h7_FC00_0001;
    localparam int               IN_PIPE   = 1;
    localparam int               RES_DEPTH = 4;
    localparam int               REQ_W     = $clog2(NB_REQ);
    localparam int               CRED_W    = $clog2(RES_DEPTH + 1);
    localparam int               LAT       = arith_mult_cst_solinas2_pkg::get_latency() + IN_PIPE;
    localparam logic [REQ_W-1:0] RST_SIDE  = REQ_W'(1);

    typedef logic [REQ_W-1:0] req_idx_t;

    // Scan from the far end back toward ptr so the closest eligible index wins.
    function automatic logic [NB_REQ-1:0] rr_pick(input logic [NB_REQ-1:0] vld_mask,
                                                  input req_idx_t ptr);
        logic [NB_REQ-1:0] gnt;
        int                idx;
        gnt = '0;
        for (int k = NB_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NB_REQ;
            if (vld_mask[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/arith_mult_cst_solinas2_pkg.sv
// Latency query for the constant multiplier so users can size credits and
// align timing without knowing its internal stage count.
package arith_mult_cst_solinas2_pkg;

    localparam int MULT_STAGES = 2;

    function automatic int get_latency();
        return MULT_STAGES;
    endfunction

endpackage

// File: rtl/arith_mult_cst_arb_fifo.sv
// Per-requester result FIFO plus the credit counter that reserves its slots
// at grant time, so a write can never find the FIFO full.
module arith_mult_cst_arb_fifo
    import arith_mult_cst_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           s_rst,
    input  logic           wr,
    input  logic [Z_W-1:0] wr_data,
    input  logic           rd,
    input  logic           take,
    output logic [Z_W-1:0] rd_data,
    output logic           empty,
    output logic           has_credit
);

    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    logic [Z_W-1:0]    mem [RES_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CRED_W-1:0] count;
    logic [CRED_W-1:0] credit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            credit <= CRED_W'(RES_DEPTH);
        end else begin
            if (wr) wr_ptr <= ptr_inc(wr_ptr);
            if (rd) rd_ptr <= ptr_inc(rd_ptr);
            if (wr && !rd)      count <= count + CRED_W'(1);
            else if (rd && !wr) count <= count - CRED_W'(1);
            if (take && !rd)      credit <= credit - CRED_W'(1);
            else if (rd && !take) credit <= credit + CRED_W'(1);
        end
    end

    assign rd_data    = mem[rd_ptr];
    assign empty      = (count == '0);
    assign has_credit = (credit != '0);

endmodule

// File: rtl/arith_mult_cst_solinas2.sv
// Exact a*CST multiplier: optional input register, then two stages (split
// partial products, then recombine). A side tag travels alongside each operand.
module arith_mult_cst_solinas2
    import arith_mult_cst_solinas2_pkg::*;
#(
    parameter int                IN_W     = 17,
    parameter int                CST_W    = 35,
    parameter logic [CST_W-1:0]  CST      = 35'h7_FC00_0001,
    parameter int                IN_PIPE  = 1,
    parameter int                SIDE_W   = 2,
    parameter logic [SIDE_W-1:0] RST_SIDE = '0
) (
    input  logic                  clk,
    input  logic                  s_rst_n,
    input  logic                  in_avail,
    input  logic [IN_W-1:0]       in_a,
    input  logic [SIDE_W-1:0]     in_side,
    output logic                  out_avail,
    output logic [IN_W+CST_W-1:0] out_z,
    output logic [SIDE_W-1:0]     out_side
);

    localparam int LO_W = CST_W / 2;
    localparam int HI_W = CST_W - LO_W;
    localparam int PL_W = IN_W + LO_W;
    localparam int PH_W = IN_W + HI_W;
    localparam int Z_W  = IN_W + CST_W;
    localparam logic [LO_W-1:0] CST_LO = CST[LO_W-1:0];
    localparam logic [HI_W-1:0] CST_HI = CST[CST_W-1:LO_W];

    logic              p_vld;
    logic [IN_W-1:0]   p_a;
    logic [SIDE_W-1:0] p_side;

    if (IN_PIPE != 0) begin : g_in_pipe
        always_ff @(posedge clk) begin
            if (!s_rst_n) begin
                p_vld  <= 1'b0;
                p_a    <= '0;
                p_side <= RST_SIDE;
            end else begin
                p_vld  <= in_avail;
                p_a    <= in_a;
                p_side <= in_side;
            end
        end
    end else begin : g_no_pipe
        assign p_vld  = in_avail;
        assign p_a    = in_a;
        assign p_side = in_side;
    end

    logic              s1_vld;
    logic [SIDE_W-1:0] s1_side;
    logic [PL_W-1:0]   s1_lo;
    logic [PH_W-1:0]   s1_hi;

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            s1_vld    <= 1'b0;
            s1_side   <= RST_SIDE;
            s1_lo     <= '0;
            s1_hi     <= '0;
            out_avail <= 1'b0;
            out_side  <= RST_SIDE;
            out_z     <= '0;
        end else begin
            s1_vld    <= p_vld;
            s1_side   <= p_side;
            s1_lo     <= PL_W'(p_a) * PL_W'(CST_LO);
            s1_hi     <= PH_W'(p_a) * PH_W'(CST_HI);
            // a*CST = (a*CST_HI << LO_W) + a*CST_LO
            out_avail <= s1_vld;
            out_side  <= s1_side;
            out_z     <= {s1_hi, {LO_W{1'b0}}} + Z_W'(s1_lo);
        end
    end

endmodule

// File: rtl/arith_mult_cst_arbiter.sv
// Shares one constant multiplier among NB_REQ requesters with credit-backed result FIFOs.
// ARITH_MULT_CST_ARB_RR_EN defined: round-robin grant; undefined: lowest index wins.
module arith_mult_cst_arbiter
    import arith_mult_cst_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   s_rst,
    input  logic [NB_REQ-1:0]      in_vld,
    input  logic [NB_REQ*IN_W-1:0] in_a,
    output logic [NB_REQ-1:0]      in_rdy,
    output logic [NB_REQ-1:0]      out_vld,
    output logic [NB_REQ*Z_W-1:0]  out_z,
    input  logic [NB_REQ-1:0]      out_rdy
);

    logic [NB_REQ-1:0] has_credit;
    logic [NB_REQ-1:0] fifo_empty;
    logic [NB_REQ-1:0] eligible;
    logic [NB_REQ-1:0] grant;
    logic              mult_vld;
    logic [IN_W-1:0]   mult_a;
    req_idx_t          mult_side;
    logic              prod_vld;
    logic [Z_W-1:0]    prod_z;
    req_idx_t          prod_side;

    // Nothing is accepted while reset is held, so no credit is spent on a discarded operand.
    assign eligible = in_vld & has_credit & {NB_REQ{~s_rst}};

`ifdef ARITH_MULT_CST_ARB_RR_EN
    req_idx_t rr_ptr;

    assign grant = rr_pick(eligible, rr_ptr);

    always_ff @(posedge clk) begin
        if (s_rst) begin
            rr_ptr <= '0;
        end else if (mult_vld) begin
            rr_ptr <= (mult_side == REQ_W'(NB_REQ - 1)) ? '0 : mult_side + REQ_W'(1);
        end
    end
`else
    assign grant = rr_pick(eligible, '0);
`endif

    assign in_rdy   = grant;
    assign mult_vld = |grant;

    always_comb begin
        mult_a    = '0;
        mult_side = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (grant[i]) begin
                mult_a    = in_a[i*IN_W +: IN_W];
                mult_side = REQ_W'(i);
            end
        end
    end

    arith_mult_cst_solinas2 #(
        .IN_W     (IN_W),
        .CST_W    (CST_W),
        .CST      (CST),
        .IN_PIPE  (IN_PIPE),
        .SIDE_W   (REQ_W),
        .RST_SIDE (RST_SIDE)
    ) u_mult (
        .clk       (clk),
        .s_rst_n   (~s_rst),
        .in_avail  (mult_vld),
        .in_a      (mult_a),
        .in_side   (mult_side),
        .out_avail (prod_vld),
        .out_z     (prod_z),
        .out_side  (prod_side)
    );

    for (genvar i = 0; i < NB_REQ; i++) begin : g_req
        logic [Z_W-1:0] head;

        arith_mult_cst_arb_fifo u_fifo (
            .clk        (clk),
            .s_rst      (s_rst),
            .wr         (prod_vld && (prod_side == REQ_W'(i))),
            .wr_data    (prod_z),
            .rd         (out_vld[i] & out_rdy[i]),
            .take       (grant[i]),
            .rd_data    (head),
            .empty      (fifo_empty[i]),
            .has_credit (has_credit[i])
        );

        assign out_vld[i]             = ~fifo_empty[i];
        assign out_z[i*Z_W +: Z_W]    = fifo_empty[i] ? '0 : head;
    end

endmodule
